// File: rtl/wrchk_pkg.sv
// Shared types and constants for mem_write_checker: checker states, verdict
// encoding and the expected-store entry layout.
package wrchk_pkg;

   localparam int unsigned WRCHK_ADDR_W = 32;
   localparam int unsigned WRCHK_DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TOUT
   } state_e;

   // Verdict vector ordering is {pass, fail, timeout}
   localparam logic [2:0] VERDICT_NONE = 3'b000;
   localparam logic [2:0] VERDICT_PASS = 3'b100;
   localparam logic [2:0] VERDICT_FAIL = 3'b010;
   localparam logic [2:0] VERDICT_TOUT = 3'b001;

   typedef struct packed {
      logic [WRCHK_ADDR_W-1:0] addr;
      logic [WRCHK_DATA_W-1:0] data;
   } exp_entry_t;

endpackage

// File: rtl/wrchk_exp_mem.sv
// DEPTH-entry register file of expected stores: one synchronous write port,
// one combinational read port, contents cleared by asynchronous reset.
module wrchk_exp_mem
   import wrchk_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  exp_entry_t       wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output exp_entry_t       rdata_o
);

   exp_entry_t mem_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // The pointer can sit one past the last entry after a PASS
   assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/mem_write_checker.sv
// In-order store checker for processor benches: compares MemWrite traffic to a
// preloaded expected list. Optional PC capture: MEM_WRITE_CHECKER_PC_LOG_EN.
module mem_write_checker
   import wrchk_pkg::*;
#(
   parameter  int unsigned ADDR_W = 32,
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 8,
   parameter  int unsigned TMO_W  = 16,
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   input  logic              clear,
   input  logic [TMO_W-1:0]  timeout_limit,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [IDX_W-1:0]  err_index,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_data,
   output logic [TMO_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  writes_seen
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
   ,
   input  logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] err_pc
`endif
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  ptr_q, ptr_d;
   logic [TMO_W-1:0]  cycle_q, cycle_d, cycle_inc;
   logic [IDX_W-1:0]  err_idx_q, err_idx_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [DATA_W-1:0] err_data_q, err_data_d;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
   logic [ADDR_W-1:0] err_pc_q, err_pc_d;
`endif
   logic              ready_w, load_hs, hit, last;
   logic [2:0]        verdict;
   exp_entry_t        wr_entry, rd_entry;

   assign ready_w   = reset && (state_q == ST_IDLE) && (count_q < CNT_W'(DEPTH));
   assign load_hs   = load_valid && ready_w && !clear;
   assign wr_entry  = '{addr: WRCHK_ADDR_W'(load_addr), data: WRCHK_DATA_W'(load_data)};
   assign hit       = (ADDR_W'(rd_entry.addr) == DataAdr) && (DATA_W'(rd_entry.data) == WriteData);
   assign last      = ((ptr_q + CNT_W'(1)) == count_q);
   assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + TMO_W'(1);

   wrchk_exp_mem #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_exp_mem (
      .clk_i   (clk),
      .rst_ni  (reset),
      .we_i    (load_hs),
      .waddr_i (IDX_W'(count_q)),
      .wdata_i (wr_entry),
      .raddr_i (IDX_W'(ptr_q)),
      .rdata_o (rd_entry)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      ptr_d      = ptr_q;
      cycle_d    = cycle_q;
      err_idx_d  = err_idx_q;
      err_addr_d = err_addr_q;
      err_data_d = err_data_q;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
      err_pc_d   = err_pc_q;
`endif
      if (clear) begin
         state_d    = ST_IDLE;
         count_d    = '0;
         ptr_d      = '0;
         cycle_d    = '0;
         err_idx_d  = '0;
         err_addr_d = '0;
         err_data_d = '0;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
         err_pc_d   = '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_hs) count_d = count_q + CNT_W'(1);
               // A load accepted alongside start is already counted in count_d
               if (start) begin
                  ptr_d   = '0;
                  cycle_d = '0;
                  state_d = (count_d == '0) ? ST_PASS : ST_RUN;
               end
            end
            ST_RUN: begin
               cycle_d = cycle_inc;
               if (MemWrite && hit) begin
                  ptr_d = ptr_q + CNT_W'(1);
                  if (last) state_d = ST_PASS;
               end else if (MemWrite) begin
                  state_d    = ST_FAIL;
                  err_idx_d  = IDX_W'(ptr_q);
                  err_addr_d = DataAdr;
                  err_data_d = WriteData;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
                  err_pc_d   = PC;
`endif
               end
               if ((state_d == ST_RUN) && (timeout_limit != '0) && (cycle_inc == timeout_limit)) begin
                  state_d = ST_TOUT;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         ptr_q      <= '0;
         cycle_q    <= '0;
         err_idx_q  <= '0;
         err_addr_q <= '0;
         err_data_q <= '0;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
         err_pc_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         ptr_q      <= ptr_d;
         cycle_q    <= cycle_d;
         err_idx_q  <= err_idx_d;
         err_addr_q <= err_addr_d;
         err_data_q <= err_data_d;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
         err_pc_q   <= err_pc_d;
`endif
      end
   end

   always_comb begin
      case (state_q)
         ST_PASS: verdict = VERDICT_PASS;
         ST_FAIL: verdict = VERDICT_FAIL;
         ST_TOUT: verdict = VERDICT_TOUT;
         default: verdict = VERDICT_NONE;
      endcase
   end

   assign {pass, fail, timeout} = verdict;
   assign done        = (verdict != VERDICT_NONE);
   assign load_ready  = ready_w;
   assign err_index   = err_idx_q;
   assign err_addr    = err_addr_q;
   assign err_data    = err_data_q;
   assign cycle_count = cycle_q;
   assign writes_seen = ptr_q;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
   assign err_pc      = err_pc_q;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: a list-walking reference model
// predicts each verdict, a negedge monitor compares when done rises.
module tb_mem_write_checker;

   localparam int DEPTH = 8;

   typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
   typedef struct { bit v; logic [31:0] a; logic [31:0] d; } store_t;
   typedef struct {
      bit p; bit f; bit t;
      int idx; logic [31:0] ea; logic [31:0] ed; logic [31:0] epc;
      int cyc; int ws;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [31:0] load_addr = '0;
   logic [31:0] load_data = '0;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] timeout_limit = '0;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic        done, pass, fail, timeout;
   logic [2:0]  err_index;
   logic [31:0] err_addr, err_data;
   logic [15:0] cycle_count;
   logic [3:0]  writes_seen;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
   logic [31:0] PC = '0;
   logic [31:0] err_pc;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic done_prev = 1'b0;

   mem_write_checker #(
      .ADDR_W (32),
      .DATA_W (32),
      .DEPTH  (DEPTH),
      .TMO_W  (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .load_valid    (load_valid),
      .load_ready    (load_ready),
      .load_addr     (load_addr),
      .load_data     (load_data),
      .start         (start),
      .clear         (clear),
      .timeout_limit (timeout_limit),
      .MemWrite      (MemWrite),
      .DataAdr       (DataAdr),
      .WriteData     (WriteData),
      .done          (done),
      .pass          (pass),
      .fail          (fail),
      .timeout       (timeout),
      .err_index     (err_index),
      .err_addr      (err_addr),
      .err_data      (err_data),
      .cycle_count   (cycle_count),
      .writes_seen   (writes_seen)
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
      ,
      .PC            (PC),
      .err_pc        (err_pc)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] pc_of(input int k);
      return 32'(4 * (k + 14));
   endfunction

   function automatic ent_t mk_ent(input logic [31:0] a, input logic [31:0] d);
      ent_t x;
      x.a = a; x.d = d;
      return x;
   endfunction

   function automatic store_t mk_st(input bit v, input logic [31:0] a, input logic [31:0] d);
      store_t s;
      s.v = v; s.a = a; s.d = d;
      return s;
   endfunction

   // Walks the expected list against the store schedule one RUN cycle at a time
   function automatic exp_t predict(input ent_t ents[$], input store_t sch[$], input int lim);
      exp_t e;
      int   ptr = 0;
      e = '{p: 0, f: 0, t: 0, idx: 0, ea: '0, ed: '0, epc: '0, cyc: -1, ws: 0};
      if (ents.size() == 0) begin
         e.p = 1; e.cyc = 0;
         return e;
      end
      for (int k = 1; k <= sch.size(); k++) begin
         if (sch[k-1].v) begin
            if (sch[k-1].a == ents[ptr].a && sch[k-1].d == ents[ptr].d) begin
               ptr++;
               if (ptr == ents.size()) begin
                  e.p = 1; e.cyc = k; e.ws = ptr;
                  return e;
               end
            end else begin
               e.f = 1; e.idx = ptr; e.ea = sch[k-1].a; e.ed = sch[k-1].d;
               e.epc = pc_of(k); e.cyc = k; e.ws = ptr;
               return e;
            end
         end
         if (lim != 0 && k == lim) begin
            e.t = 1; e.cyc = k; e.ws = ptr;
            return e;
         end
      end
      e.ws = ptr;
      return e;
   endfunction

   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_verdict", 1'b1, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("verdict", {pass, fail, timeout}, {mon_e.p, mon_e.f, mon_e.t});
            chk("err_index", err_index, mon_e.idx);
            chk("err_addr", err_addr, mon_e.ea);
            chk("err_data", err_data, mon_e.ed);
            chk("cycle_count", cycle_count, mon_e.cyc);
            chk("writes_seen", writes_seen, mon_e.ws);
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
            chk("err_pc", err_pc, mon_e.epc);
`endif
         end
      end
      done_prev = done;
   end

   task automatic load_list(input ent_t ents[$], input bit overlap);
      for (int i = 0; i < ents.size(); i++) begin
         load_valid = 1'b1;
         load_addr  = ents[i].a;
         load_data  = ents[i].d;
         start      = overlap && (i == ents.size() - 1);
         chk("load_ready", load_ready, 1'b1);
         @(posedge clk); #1;
      end
      load_valid = 1'b0;
      if (!(overlap && ents.size() > 0)) begin
         start = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic run_scn(input ent_t ents[$], input store_t sch[$], input int lim,
                          input bit overlap, input bit offer_extra);
      exp_t e;
      e = predict(ents, sch, lim);
      timeout_limit = 16'(lim);
      if (e.cyc >= 0) exp_q.push_back(e);
      if (offer_extra) begin
         for (int i = 0; i < ents.size(); i++) begin
            load_valid = 1'b1; load_addr = ents[i].a; load_data = ents[i].d;
            @(posedge clk); #1;
         end
         load_addr = 32'hDEAD_0000; load_data = 32'h5;
         chk("full_load_ready", load_ready, 1'b0);
         @(posedge clk); #1;
         load_valid = 1'b0;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end else begin
         load_list(ents, overlap);
      end
      for (int k = 0; k < sch.size() && !done; k++) begin
         MemWrite = sch[k].v; DataAdr = sch[k].a; WriteData = sch[k].d;
`ifdef MEM_WRITE_CHECKER_PC_LOG_EN
         PC = pc_of(k + 1);
`endif
         @(posedge clk); #1;
      end
      MemWrite = 1'b0;
      if (e.cyc < 0) begin
         chk("still_running", done, 1'b0);
         chk("run_cycles", cycle_count, sch.size());
      end else begin
         for (int w = 0; w < 5 && !done; w++) begin
            @(posedge clk); #1;
         end
         MemWrite = 1'b1; start = 1'b1;
         DataAdr   = (ents.size() > 0) ? ents[0].a : '0;
         WriteData = (ents.size() > 0) ? ents[0].d : '0;
         repeat (2) @(posedge clk);
         #1;
         MemWrite = 1'b0; start = 1'b0;
         chk("sticky_verdict", {pass, fail, timeout}, {e.p, e.f, e.t});
         chk("sticky_err_addr", err_addr, e.ea);
      end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clear_done", done, 1'b0);
      chk("clear_ready", load_ready, 1'b1);
      chk("clear_err", {err_index, err_addr, err_data}, '0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   initial begin : main
      ent_t   ents[$];
      store_t sch[$];
      int     n, lim;
      store_t s;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {load_ready, done, pass, fail, timeout, err_index, err_addr,
                            err_data, cycle_count, writes_seen}, '0);
      reset = 1'b1;
      #1;
      chk("reset_release_ready", load_ready, 1'b1);

      // Two matching stores with a gap
      ents.delete(); sch.delete();
      ents.push_back(mk_ent(100, 7)); ents.push_back(mk_ent(128, 254));
      sch.push_back(mk_st(1, 100, 7)); sch.push_back(mk_st(0, 0, 0)); sch.push_back(mk_st(1, 128, 254));
      run_scn(ents, sch, 0, 0, 0);

      // Mismatch, PC at that cycle is 0x3C
      ents.delete(); sch.delete();
      ents.push_back(mk_ent(128, 254));
      sch.push_back(mk_st(1, 128, 255));
      run_scn(ents, sch, 0, 0, 0);

      // Timeout at 15 with no stores
      ents.delete(); sch.delete();
      ents.push_back(mk_ent(8, 1));
      for (int i = 0; i < 20; i++) sch.push_back(mk_st(0, 8, 1));
      run_scn(ents, sch, 15, 0, 0);

      // Timeout disabled: 200 idle cycles stays in RUN
      sch.delete();
      for (int i = 0; i < 200; i++) sch.push_back(mk_st(0, 8, 1));
      run_scn(ents, sch, 0, 0, 0);

      // Full list plus refused ninth entry
      ents.delete(); sch.delete();
      for (int i = 0; i < DEPTH; i++) begin
         ents.push_back(mk_ent(32'(64 + 4 * i), 32'(i + 1)));
         sch.push_back(mk_st(1, 32'(64 + 4 * i), 32'(i + 1)));
      end
      run_scn(ents, sch, 0, 0, 1);

      // Final match on the timeout cycle
      ents.delete(); sch.delete();
      ents.push_back(mk_ent(4, 1)); ents.push_back(mk_ent(8, 2));
      sch.push_back(mk_st(0, 0, 0)); sch.push_back(mk_st(0, 0, 0)); sch.push_back(mk_st(1, 4, 1));
      sch.push_back(mk_st(0, 0, 0)); sch.push_back(mk_st(0, 0, 0)); sch.push_back(mk_st(1, 8, 2));
      run_scn(ents, sch, 6, 0, 0);

      // Non-final match on the timeout cycle still times out
      sch.delete();
      sch.push_back(mk_st(0, 0, 0)); sch.push_back(mk_st(1, 4, 1));
      sch.push_back(mk_st(0, 0, 0)); sch.push_back(mk_st(1, 8, 2));
      run_scn(ents, sch, 2, 1, 0);

      // Mismatch on the timeout cycle
      ents.delete(); sch.delete();
      ents.push_back(mk_ent(4, 1));
      for (int i = 0; i < 3; i++) sch.push_back(mk_st(0, 4, 1));
      sch.push_back(mk_st(1, 4, 2));
      run_scn(ents, sch, 4, 0, 0);

      // Empty list goes straight to PASS
      ents.delete(); sch.delete();
      run_scn(ents, sch, 0, 0, 0);

      // Reset mid-RUN
      ents.delete();
      ents.push_back(mk_ent(12, 3)); ents.push_back(mk_ent(16, 4));
      timeout_limit = '0;
      load_list(ents, 0);
      MemWrite = 1'b1; DataAdr = 12; WriteData = 3;
      @(posedge clk); #1;
      MemWrite = 1'b0;
      reset = 1'b0;
      #1;
      chk("midrun_reset_outputs", {load_ready, done, pass, fail, timeout, err_index, err_addr,
                                   err_data, cycle_count, writes_seen}, '0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midrun_release_ready", load_ready, 1'b1);
      chk("midrun_release_done", done, 1'b0);
      ents.delete(); sch.delete();
      run_scn(ents, sch, 0, 0, 0);

      // Randomized scenarios
      for (int s_i = 0; s_i < 30; s_i++) begin
         ents.delete(); sch.delete();
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++)
            ents.push_back(mk_ent(32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 3))));
         for (int i = 0; i < n; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--)
               sch.push_back(mk_st(0, 32'($urandom_range(0, 63)), 32'($urandom_range(0, 3))));
            s = mk_st(1, ents[i].a, ents[i].d);
            if ($urandom_range(0, 9) == 0) begin
               if ($urandom_range(0, 1) == 1) s.a = s.a ^ 32'h4;
               else s.d = s.d ^ 32'h1;
            end
            sch.push_back(s);
         end
         lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, sch.size() + 2);
         run_scn(ents, sch, lim, 1'($urandom_range(0, 1)), 0);
      end

      repeat (2) @(posedge clk);
      chk("pending_verdicts", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
